e6_timer_axil_intr_slave: RTL and testbench

AXI4-Lite slave register file and interrupt controller that responds to the S_AXI_INTR bus of the E6 timer peripheral.
- Latches event pulses from the timer core into a status register.
- Masks them with per-source and global enables.
- Drives a single registered irq line to the processor.
- Software acknowledges events by write-1-to-clear.

---
 rtl/e6_timer_axil_intr_slave.sv | 170 +++++++++++++++++
 tb/tb_e6_timer_axil_intr_slave.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e6_timer_axil_intr_slave.sv
// AXI4-Lite interrupt controller for the E6 timer: latches source events into ISR,
// masks them with IER/GIE, and drives one registered irq; IAR is write-1-to-clear.
module e6_timer_axil_intr_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter int          C_NUM_OF_INTR      = 1,
  parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFFFFFF,
  parameter int          C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                            s_axi_intr_aclk,
  input  logic                            s_axi_intr_aresetn,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_awaddr,
  input  logic [2:0]                      s_axi_intr_awprot,
  input  logic                            s_axi_intr_awvalid,
  output logic                            s_axi_intr_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_intr_wstrb,
  input  logic                            s_axi_intr_wvalid,
  output logic                            s_axi_intr_wready,
  output logic [1:0]                      s_axi_intr_bresp,
  output logic                            s_axi_intr_bvalid,
  input  logic                            s_axi_intr_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_araddr,
  input  logic [2:0]                      s_axi_intr_arprot,
  input  logic                            s_axi_intr_arvalid,
  output logic                            s_axi_intr_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_rdata,
  output logic [1:0]                      s_axi_intr_rresp,
  output logic                            s_axi_intr_rvalid,
  input  logic                            s_axi_intr_rready,
  output logic                            irq
);

  localparam int             N         = C_NUM_OF_INTR;
  localparam int             DW        = C_S_AXI_DATA_WIDTH;
  localparam logic [N-1:0]   EDGE_SENS = C_INTR_SENSITIVITY[N-1:0];
  localparam logic           IRQ_ON    = (C_IRQ_ACTIVE_STATE != 0);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t      w_state;
  r_state_t      r_state;
  logic          gie;
  logic [N-1:0]  ier;
  logic [N-1:0]  isr;
  logic [N-1:0]  src_d;
  logic [DW-1:0] lane_mask;
  logic [DW-1:0] wr_val;
  logic [DW-1:0] rd_word;
  logic [2:0]    wr_idx;
  logic [2:0]    rd_idx;
  logic          wr_fire;
  logic [N-1:0]  ev_set;
  logic [N-1:0]  ev_clr;
  logic          unused_ok;

  assign s_axi_intr_bresp = 2'b00;
  assign s_axi_intr_rresp = 2'b00;

  assign wr_idx  = s_axi_intr_awaddr[4:2];
  assign rd_idx  = s_axi_intr_araddr[4:2];
  assign wr_fire = (w_state == W_IDLE) && s_axi_intr_awready
                   && s_axi_intr_awvalid && s_axi_intr_wvalid;

  always_comb begin
    lane_mask = '0;
    for (int unsigned b = 0; b < DW/8; b++)
      lane_mask[8*b +: 8] = {8{s_axi_intr_wstrb[b]}};
  end

  assign wr_val = s_axi_intr_wdata & lane_mask;

  // Edge sources fire on a 0->1 transition; level sources fire every cycle they are high.
  assign ev_set = (intr_src & ~src_d & EDGE_SENS) | (intr_src & ~EDGE_SENS);
  assign ev_clr = (wr_fire && wr_idx == 3'd3) ? wr_val[N-1:0] : '0;

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      3'd0:    rd_word[0]     = gie;
      3'd1:    rd_word[N-1:0] = ier;
      3'd2:    rd_word[N-1:0] = isr;
      3'd4:    rd_word[N-1:0] = isr & ier;
      default: rd_word        = '0;
    endcase
  end

  // Both readies rise together only once AW and W are both presented.
  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      w_state            <= W_IDLE;
      s_axi_intr_awready <= 1'b0;
      s_axi_intr_wready  <= 1'b0;
      s_axi_intr_bvalid  <= 1'b0;
      gie                <= 1'b0;
      ier                <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            s_axi_intr_awready <= 1'b0;
            s_axi_intr_wready  <= 1'b0;
            s_axi_intr_bvalid  <= 1'b1;
            w_state            <= W_RESP;
            if (wr_idx == 3'd0 && s_axi_intr_wstrb[0])
              gie <= s_axi_intr_wdata[0];
            if (wr_idx == 3'd1)
              ier <= (ier & ~lane_mask[N-1:0]) | wr_val[N-1:0];
          end else begin
            s_axi_intr_awready <= s_axi_intr_awvalid & s_axi_intr_wvalid;
            s_axi_intr_wready  <= s_axi_intr_awvalid & s_axi_intr_wvalid;
          end
        end
        W_RESP: begin
          if (s_axi_intr_bready) begin
            s_axi_intr_bvalid <= 1'b0;
            w_state           <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      r_state            <= R_IDLE;
      s_axi_intr_arready <= 1'b0;
      s_axi_intr_rvalid  <= 1'b0;
      s_axi_intr_rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_intr_arready && s_axi_intr_arvalid) begin
            s_axi_intr_arready <= 1'b0;
            s_axi_intr_rvalid  <= 1'b1;
            s_axi_intr_rdata   <= rd_word;
            r_state            <= R_DATA;
          end else begin
            s_axi_intr_arready <= s_axi_intr_arvalid;
          end
        end
        R_DATA: begin
          if (s_axi_intr_rready) begin
            s_axi_intr_rvalid <= 1'b0;
            r_state           <= R_IDLE;
          end
        end
      endcase
    end
  end

  // A set and a clear on the same bit in one cycle leaves the bit set.
  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      src_d <= '0;
      isr   <= '0;
      irq   <= ~IRQ_ON;
    end else begin
      src_d <= intr_src;
      isr   <= (isr & ~ev_clr) | ev_set;
      irq   <= (gie && (|(isr & ier))) ? IRQ_ON : ~IRQ_ON;
    end
  end

  assign unused_ok = ^{s_axi_intr_awprot, s_axi_intr_arprot,
                       s_axi_intr_awaddr, s_axi_intr_araddr, wr_val};

endmodule

// File: tb/tb_e6_timer_axil_intr_slave.sv
// Bench for e6_timer_axil_intr_slave: register table, directed corner sequences and
// randomized traffic, all checked against a cycle-level register/event model.
module tb_e6_timer_axil_intr_slave;

  localparam int             N    = 4;
  localparam logic [31:0]    SENS = 32'h0000_0005;
  localparam logic [N-1:0]   EDGE = SENS[N-1:0];

  logic          clk = 1'b0;
  logic          aresetn;
  logic [N-1:0]  intr_src;
  logic [4:0]    awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, irq;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  e6_timer_axil_intr_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .C_NUM_OF_INTR      (N),
    .C_INTR_SENSITIVITY (SENS),
    .C_IRQ_ACTIVE_STATE (1)
  ) dut (
    .s_axi_intr_aclk    (clk),
    .s_axi_intr_aresetn (aresetn),
    .intr_src           (intr_src),
    .s_axi_intr_awaddr  (awaddr),
    .s_axi_intr_awprot  (awprot),
    .s_axi_intr_awvalid (awvalid),
    .s_axi_intr_awready (awready),
    .s_axi_intr_wdata   (wdata),
    .s_axi_intr_wstrb   (wstrb),
    .s_axi_intr_wvalid  (wvalid),
    .s_axi_intr_wready  (wready),
    .s_axi_intr_bresp   (bresp),
    .s_axi_intr_bvalid  (bvalid),
    .s_axi_intr_bready  (bready),
    .s_axi_intr_araddr  (araddr),
    .s_axi_intr_arprot  (arprot),
    .s_axi_intr_arvalid (arvalid),
    .s_axi_intr_arready (arready),
    .s_axi_intr_rdata   (rdata),
    .s_axi_intr_rresp   (rresp),
    .s_axi_intr_rvalid  (rvalid),
    .s_axi_intr_rready  (rready),
    .irq                (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic         m_gie;
  logic [N-1:0] m_ier, m_isr, m_src_d;
  logic         m_irq;
  logic         m_wr;
  logic [4:0]   m_wa;
  logic [31:0]  m_wd;
  logic [3:0]   m_ws;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gie = 1'b0; m_ier = '0; m_isr = '0; m_src_d = '0; m_irq = 1'b0; m_wr = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a[4:2])
      3'd0:    r[0]     = m_gie;
      3'd1:    r[N-1:0] = m_ier;
      3'd2:    r[N-1:0] = m_isr;
      3'd4:    r[N-1:0] = m_isr & m_ier;
      default: r        = '0;
    endcase
    return r;
  endfunction

  // One clock: model advances on the edge from the inputs held across it; irq checked after.
  task automatic tick();
    logic [N-1:0] set_v, clr_v, n_ier, cur_src;
    logic [31:0]  m;
    logic         n_gie, n_irq;
    cur_src = intr_src;
    set_v   = cur_src & (~m_src_d | ~EDGE);
    clr_v   = '0;
    n_gie   = m_gie;
    n_ier   = m_ier;
    n_irq   = m_gie && ((m_isr & m_ier) != '0);
    if (m_wr) begin
      m = '0;
      for (int b = 0; b < 4; b++) if (m_ws[b]) m[8*b +: 8] = 8'hFF;
      case (m_wa[4:2])
        3'd0:    if (m_ws[0]) n_gie = m_wd[0];
        3'd1:    n_ier = (m_ier & ~m[N-1:0]) | (m_wd[N-1:0] & m[N-1:0]);
        3'd3:    clr_v = m_wd[N-1:0] & m[N-1:0];
        default: ;
      endcase
    end
    @(posedge clk);
    m_isr   = (m_isr & ~clr_v) | set_v;
    m_src_d = cur_src;
    m_gie   = n_gie;
    m_ier   = n_ier;
    m_irq   = n_irq;
    m_wr    = 1'b0;
    @(negedge clk);
    check1("irq", irq, m_irq);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [N-1:0] hs_src);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    check1("awready_pre", awready, 1'b0);
    tick();
    check1("awready", awready, 1'b1);
    check1("wready", wready, 1'b1);
    m_wr = 1'b1; m_wa = a; m_wd = d; m_ws = s;
    intr_src = hs_src;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; intr_src = '0;
    check1("bvalid", bvalid, 1'b1);
    check1("awready_post", awready, 1'b0);
    check32("bresp", {30'd0, bresp}, 32'd0);
    tick();
    check1("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    logic [31:0] exp;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    check1("arready", arready, 1'b1);
    exp = model_read(a);
    tick();
    arvalid = 1'b0;
    check1("rvalid", rvalid, 1'b1);
    check32("rdata_model", rdata, exp);
    check32("rresp", {30'd0, rresp}, 32'd0);
    d = rdata;
    tick();
    check1("rvalid_drop", rvalid, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] held;
    int unsigned op;

    aresetn = 1'b0; intr_src = '0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check1("rst_awready", awready, 1'b0);
    check1("rst_wready", wready, 1'b0);
    check1("rst_bvalid", bvalid, 1'b0);
    check1("rst_arready", arready, 1'b0);
    check1("rst_rvalid", rvalid, 1'b0);
    check32("rst_rdata", rdata, 32'd0);
    check1("rst_irq", irq, 1'b0);
    aresetn = 1'b1;
    tick();

    // Register-map table: {write?, addr, data, strb, expected read}
    vecs.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'h08, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'h10, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h00, 32'hFFFF_FFFE, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h00, 32'h1, 4'hE, 32'h0});
    vecs.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'hF});
    vecs.push_back('{1'b1, 5'h04, 32'h0, 4'hE, 32'h0});
    vecs.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'hF});
    vecs.push_back('{1'b1, 5'h04, 32'hFFFF_FFFA, 4'h1, 32'h0});
    vecs.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'hA});
    vecs.push_back('{1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h14, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'h1C, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h04, 32'h0, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h00, 32'h1, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h1});
    vecs.push_back('{1'b0, 5'h10, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'h01, 32'h0, 4'h0, 32'h1});
    foreach (vecs[i]) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, '0);
      else begin
        axi_read(vecs[i].addr, d);
        check32($sformatf("table_%0d", i), d, vecs[i].exp);
      end
    end

    // Pulse with GIE=IER=1: irq two edges after the pulse cycle
    axi_write(5'h04, 32'h1, 4'hF, '0);
    intr_src = 4'b0001; tick();
    check1("irq_1cyc", irq, 1'b0);
    intr_src = '0; tick();
    check1("irq_2cyc", irq, 1'b1);
    axi_read(5'h08, d); check32("isr_pulse", d, 32'h1);
    axi_read(5'h10, d); check32("ipr_pulse", d, 32'h1);

    // IAR acknowledge
    axi_write(5'h0C, 32'h1, 4'hF, '0);
    check1("irq_after_iar", irq, 1'b0);
    axi_read(5'h10, d); check32("ipr_after_iar", d, 32'h0);
    axi_read(5'h0C, d); check32("iar_reads_0", d, 32'h0);

    // Masked source, then enable
    axi_write(5'h04, 32'h0, 4'hF, '0);
    intr_src = 4'b0001; tick(); intr_src = '0; tick(); tick();
    check1("irq_masked", irq, 1'b0);
    axi_read(5'h08, d); check32("isr_masked", d, 32'h1);
    axi_read(5'h10, d); check32("ipr_masked", d, 32'h0);
    axi_write(5'h04, 32'h1, 4'hF, '0);
    check1("irq_after_ier", irq, 1'b1);

    // Set beats a simultaneous clear
    axi_write(5'h0C, 32'h1, 4'hF, '0);
    axi_read(5'h08, d); check32("isr_cleared", d, 32'h0);
    axi_write(5'h0C, 32'h1, 4'hF, 4'b0001);
    axi_read(5'h08, d); check32("isr_set_wins", d, 32'h1);
    intr_src = 4'b0010; tick();
    axi_write(5'h0C, 32'h2, 4'hF, 4'b0010);
    axi_read(5'h08, d); check32("isr_level_held", d, 32'h3);
    axi_write(5'h0C, 32'hF, 4'hF, '0);
    axi_read(5'h08, d); check32("isr_all_clear", d, 32'h0);

    // AW without W, then B back-pressure with a second write waiting
    awaddr = 5'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("awready_aw_only", awready, 1'b0);
      check1("wready_aw_only", wready, 1'b0);
    end
    wvalid = 1'b1; tick();
    check1("awready_both", awready, 1'b1);
    m_wr = 1'b1; m_wa = awaddr; m_wd = wdata; m_ws = wstrb;
    tick();
    check1("bvalid_rise", bvalid, 1'b1);
    awaddr = 5'h00; wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("bvalid_hold", bvalid, 1'b1);
      check1("awready_blocked", awready, 1'b0);
    end
    bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0; tick();
    check1("bvalid_release", bvalid, 1'b0);
    axi_read(5'h00, d); check32("gie_untouched", d, 32'h1);
    axi_read(5'h04, d); check32("ier_bp_write", d, 32'h3);

    // R back-pressure
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0; tick();
    check1("arready_hold", arready, 1'b1);
    tick(); arvalid = 1'b0;
    check1("rvalid_hold0", rvalid, 1'b1);
    held = 32'h3;
    check32("rdata_hold0", rdata, held);
    for (int i = 0; i < 4; i++) begin
      araddr = 5'($urandom);
      tick();
      check1("rvalid_hold", rvalid, 1'b1);
      check32("rdata_hold", rdata, held);
    end
    rready = 1'b1; tick();
    check1("rvalid_hold_drop", rvalid, 1'b0);

    // Reset while rvalid is high
    araddr = 5'h08; arvalid = 1'b1; rready = 1'b0; tick(); tick(); arvalid = 1'b0;
    check1("rvalid_before_rst", rvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    check1("rst_async_rvalid", rvalid, 1'b0);
    check1("rst_async_arready", arready, 1'b0);
    check1("rst_async_irq", irq, 1'b0);
    model_reset();
    @(negedge clk); @(negedge clk);
    aresetn = 1'b1; rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("no_r_after_rst", rvalid, 1'b0);
    end
    axi_read(5'h04, d); check32("ier_after_rst", d, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          intr_src = N'($urandom);
          repeat ($urandom_range(1, 3)) tick();
        end
        1: axi_write({3'($urandom_range(0, 7)), 2'b00}, $urandom, 4'($urandom), N'($urandom));
        2: axi_read(5'($urandom), d);
        default: begin
          intr_src = '0;
          tick();
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
